// File: rtl/char_spawner_if.sv
// Spawn offer channel between the character spawner and the column-table writer.
// The master side drives the payload and valid; the slave side returns ready.
interface char_spawner_if #(
  parameter int COL_W = 6
) ();
  logic             spawn_valid;
  logic             spawn_ready;
  logic [7:0]       spawn_char;
  logic [COL_W-1:0] spawn_col;
  logic [2:0]       spawn_speed;

  modport master (
    output spawn_valid, spawn_char, spawn_col, spawn_speed,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid, spawn_char, spawn_col, spawn_speed,
    output spawn_ready
  );
endinterface

// File: rtl/char_spawner.sv
// Paced random spawner for falling characters: draws letter, column and speed from
// a Galois LFSR, skips busy columns and offers each spawn on a valid/ready channel.
module char_spawner #(
  parameter int          COLS             = 64,
  parameter logic [15:0] SEED             = 16'hACE1,
  parameter int          BASE_PERIOD      = 2500000,
  parameter int          PERIOD_STEP      = 150000,
  parameter int          MIN_PERIOD       = 400000,
  parameter int          SPAWNS_PER_LEVEL = 10,
  parameter int          MAX_TRIES        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [COLS-1:0]     col_busy,
  char_spawner_if.master      spawn,
  output logic [3:0]          level,
  output logic [15:0]         spawn_count,
  output logic [7:0]          drop_count
);

  localparam int          COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int          TRY_W    = $clog2(MAX_TRIES + 1);
  localparam int          LVL_W    = $clog2(SPAWNS_PER_LEVEL + 1);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_PICK = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t             state_r;
  logic [15:0]        lfsr_r;
  logic [31:0]        timer_r;
  logic [TRY_W-1:0]   tries_r;
  logic [LVL_W-1:0]   lvl_cnt_r;
  logic [3:0]         level_r;
  logic [15:0]        spawn_count_r;
  logic [7:0]         drop_count_r;
  logic               valid_r;
  logic [7:0]         char_r;
  logic [COL_W-1:0]   col_r;
  logic [2:0]         speed_r;

  logic [COL_W-1:0]   cand_col_s;
  logic               cand_ok_s;
  logic [4:0]         low5_s;
  logic [7:0]         cand_char_s;
  logic [2:0]         raw_speed_s;
  logic [4:0]         speed_cap_s;
  logic [2:0]         cand_speed_s;
  logic [3:0]         next_level_s;
  logic               level_hit_s;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // max(MIN_PERIOD, BASE_PERIOD - lvl*PERIOD_STEP) without unsigned underflow
  function automatic logic [31:0] period_of(input logic [3:0] lvl);
    logic [31:0] sub;
    sub = 32'(lvl) * 32'(PERIOD_STEP);
    if ((sub + 32'(MIN_PERIOD)) >= 32'(BASE_PERIOD)) begin
      period_of = 32'(MIN_PERIOD);
    end else begin
      period_of = 32'(BASE_PERIOD) - sub;
    end
  endfunction

  // Candidate decode from the current LFSR value and level bookkeeping for an accept
  always_comb begin
    cand_col_s   = lfsr_r[15 -: COL_W];
    cand_ok_s    = (32'(cand_col_s) < 32'(COLS)) ? !col_busy[cand_col_s] : 1'b0;
    low5_s       = lfsr_r[4:0];
    cand_char_s  = 8'h61 + ((low5_s < 5'd26) ? {3'b000, low5_s} : {3'b000, low5_s - 5'd26});
    raw_speed_s  = (lfsr_r[7:5] == 3'd0) ? 3'd1 : lfsr_r[7:5];
    speed_cap_s  = {1'b0, level_r} + 5'd1;
    // raw speed is at most 7, so the capped result already respects the 3-bit range
    cand_speed_s = ({2'b00, raw_speed_s} < speed_cap_s) ? raw_speed_s : speed_cap_s[2:0];
    level_hit_s  = (lvl_cnt_r == LVL_W'(SPAWNS_PER_LEVEL - 1));
    next_level_s = (level_hit_s && (level_r != 4'd15)) ? (level_r + 4'd1) : level_r;
  end

  // Spawn sequencer: WAIT pacing, PICK attempts, HOLD until the consumer accepts
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_WAIT;
      lfsr_r        <= SEED_EFF;
      timer_r       <= 32'(BASE_PERIOD) - 32'd1;
      tries_r       <= '0;
      lvl_cnt_r     <= '0;
      level_r       <= 4'd0;
      spawn_count_r <= 16'd0;
      drop_count_r  <= 8'd0;
      valid_r       <= 1'b0;
      char_r        <= 8'd0;
      col_r         <= '0;
      speed_r       <= 3'd0;
    end else begin
      if (en) begin
        lfsr_r <= lfsr_step(lfsr_r);
      end
      case (state_r)
        ST_WAIT: begin
          if (en) begin
            if (timer_r == 32'd0) begin
              state_r <= ST_PICK;
              tries_r <= '0;
            end else begin
              timer_r <= timer_r - 32'd1;
            end
          end
        end
        ST_PICK: begin
          if (en) begin
            if (cand_ok_s) begin
              col_r   <= cand_col_s;
              char_r  <= cand_char_s;
              speed_r <= cand_speed_s;
              valid_r <= 1'b1;
              state_r <= ST_HOLD;
            end else if (tries_r == TRY_W'(MAX_TRIES - 1)) begin
              if (drop_count_r != 8'hFF) begin
                drop_count_r <= drop_count_r + 8'd1;
              end
              timer_r <= period_of(level_r) - 32'd1;
              state_r <= ST_WAIT;
            end else begin
              tries_r <= tries_r + TRY_W'(1);
            end
          end
        end
        ST_HOLD: begin
          // the offer is never retracted, so en plays no part here
          if (valid_r && spawn.spawn_ready) begin
            valid_r       <= 1'b0;
            spawn_count_r <= spawn_count_r + 16'd1;
            lvl_cnt_r     <= level_hit_s ? '0 : (lvl_cnt_r + LVL_W'(1));
            level_r       <= next_level_s;
            timer_r       <= period_of(next_level_s) - 32'd1;
            state_r       <= ST_WAIT;
          end
        end
        default: begin
          state_r <= ST_WAIT;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign spawn.spawn_valid = valid_r;
  assign spawn.spawn_char  = char_r;
  assign spawn.spawn_col   = col_r;
  assign spawn.spawn_speed = speed_r;
  assign level             = level_r;
  assign spawn_count       = spawn_count_r;
  assign drop_count        = drop_count_r;

endmodule

// File: tb/tb_char_spawner.sv
// Bench for char_spawner: a behavioural reference pushes each expected spawn into a
// queue; the scenario tasks pop it when the DUT raises valid and compare inline.
module tb_char_spawner;
  localparam int BASE = 4;
  localparam int STEP = 1;
  localparam int MINP = 2;
  localparam int SPL  = 2;
  localparam int MAXT = 8;

  typedef struct packed {
    logic [7:0] ch;
    logic [5:0] col;
    logic [2:0] spd;
  } payload_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [63:0] col_busy;
  logic [3:0]  level;
  logic [15:0] spawn_count;
  logic [7:0]  drop_count;

  int tests_run = 0;
  int tests_failed = 0;
  payload_t exp_q[$];

  char_spawner_if #(.COL_W(6)) sp_if ();

  char_spawner #(
    .COLS(64), .SEED(16'hACE1), .BASE_PERIOD(BASE), .PERIOD_STEP(STEP),
    .MIN_PERIOD(MINP), .SPAWNS_PER_LEVEL(SPL), .MAX_TRIES(MAXT)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .col_busy(col_busy), .spawn(sp_if),
    .level(level), .spawn_count(spawn_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic int ref_period(input int lvl);
    int p;
    p = BASE - lvl * STEP;
    return (p < MINP) ? MINP : p;
  endfunction

  function automatic int ref_level(input int accepts);
    int l;
    l = accepts / SPL;
    return (l > 15) ? 15 : l;
  endfunction

  function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic payload_t ref_payload(input logic [15:0] v, input int lvl);
    payload_t p;
    int low, spd;
    low = int'(v[4:0]);
    if (low >= 26) low = low - 26;
    spd = int'(v[7:5]);
    if (spd == 0) spd = 1;
    if (spd > lvl + 1) spd = lvl + 1;
    if (spd > 7) spd = 7;
    p.ch  = 8'(97 + low);
    p.col = v[15:10];
    p.spd = 3'(spd);
    return p;
  endfunction

  // Reference model state
  int          m_state;
  logic [15:0] m_lfsr;
  int          m_timer;
  int          m_tries;
  int          m_level;
  int          m_acc;

  // Reference model of the spawner; pushes the expected payload on each accepted pick
  always @(posedge clk) begin
    if (reset) begin
      m_state <= 0; m_lfsr <= 16'hACE1; m_timer <= BASE - 1;
      m_tries <= 0; m_level <= 0; m_acc <= 0;
    end else begin
      if (en) m_lfsr <= ref_lfsr(m_lfsr);
      if (m_state == 0) begin
        if (en) begin
          if (m_timer == 0) begin m_state <= 1; m_tries <= 0; end
          else m_timer <= m_timer - 1;
        end
      end else if (m_state == 1) begin
        if (en) begin
          if (!col_busy[m_lfsr[15:10]]) begin
            exp_q.push_back(ref_payload(m_lfsr, m_level));
            m_state <= 2;
          end else if (m_tries == MAXT - 1) begin
            m_timer <= ref_period(m_level) - 1;
            m_state <= 0;
          end else begin
            m_tries <= m_tries + 1;
          end
        end
      end else begin
        if (sp_if.spawn_ready) begin
          m_acc   <= m_acc + 1;
          m_level <= ref_level(m_acc + 1);
          m_timer <= ref_period(ref_level(m_acc + 1)) - 1;
          m_state <= 0;
        end
      end
    end
  end

  task automatic do_reset(input logic en_v, input logic rdy_v, input logic [63:0] busy_v);
    @(negedge clk);
    reset = 1'b1; en = en_v; sp_if.spawn_ready = rdy_v; col_busy = busy_v;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_rise(input int limit, output int rise);
    rise = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (sp_if.spawn_valid === 1'b1) begin rise = c; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; en = 1'b1; sp_if.spawn_ready = 1'b0; col_busy = '0;
    @(negedge clk);
    tests_run++; if (sp_if.spawn_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", sp_if.spawn_valid); end
    tests_run++; if (sp_if.spawn_char !== 8'h00) begin tests_failed++; $display("FAIL rst_char: got %h want 00", sp_if.spawn_char); end
    tests_run++; if (sp_if.spawn_col !== 6'd0) begin tests_failed++; $display("FAIL rst_col: got %0d want 0", sp_if.spawn_col); end
    tests_run++; if (sp_if.spawn_speed !== 3'd0) begin tests_failed++; $display("FAIL rst_speed: got %0d want 0", sp_if.spawn_speed); end
    tests_run++; if (level !== 4'd0) begin tests_failed++; $display("FAIL rst_level: got %0d want 0", level); end
    tests_run++; if (spawn_count !== 16'd0) begin tests_failed++; $display("FAIL rst_spawn_count: got %0d want 0", spawn_count); end
    tests_run++; if (drop_count !== 8'd0) begin tests_failed++; $display("FAIL rst_drop_count: got %0d want 0", drop_count); end
  endtask

  task automatic test_first_spawn();
    int rise;
    payload_t e;
    do_reset(1'b1, 1'b1, '0);
    wait_rise(12, rise);
    tests_run++; if (rise !== 5) begin tests_failed++; $display("FAIL t1_latency: got cycle %0d want 5", rise); end
    tests_run++; if (sp_if.spawn_char !== 8'h6F) begin tests_failed++; $display("FAIL t1_char: got %h want 6f", sp_if.spawn_char); end
    tests_run++; if (sp_if.spawn_col !== 6'd7) begin tests_failed++; $display("FAIL t1_col: got %0d want 7", sp_if.spawn_col); end
    tests_run++; if (sp_if.spawn_speed !== 3'd1) begin tests_failed++; $display("FAIL t1_speed: got %0d want 1", sp_if.spawn_speed); end
    tests_run++;
    if (exp_q.size() == 0) begin tests_failed++; $display("FAIL t1_scoreboard: queue empty, want one entry"); end
    else begin
      e = exp_q.pop_front();
      if ({sp_if.spawn_char, sp_if.spawn_col, sp_if.spawn_speed} !== e) begin
        tests_failed++; $display("FAIL t1_scoreboard: got %h/%0d/%0d want %h/%0d/%0d",
          sp_if.spawn_char, sp_if.spawn_col, sp_if.spawn_speed, e.ch, e.col, e.spd);
      end
    end
    @(negedge clk);
    tests_run++; if (sp_if.spawn_valid !== 1'b0) begin tests_failed++; $display("FAIL t1_valid_drop: got %b want 0", sp_if.spawn_valid); end
    tests_run++; if (spawn_count !== 16'd1) begin tests_failed++; $display("FAIL t1_count: got %0d want 1", spawn_count); end
  endtask

  task automatic test_hold();
    int rise;
    payload_t e, held;
    do_reset(1'b1, 1'b0, '0);
    wait_rise(12, rise);
    tests_run++; if (rise !== 5) begin tests_failed++; $display("FAIL t2_latency: got cycle %0d want 5", rise); end
    held = {sp_if.spawn_char, sp_if.spawn_col, sp_if.spawn_speed};
    tests_run++;
    if (exp_q.size() == 0) begin tests_failed++; $display("FAIL t2_scoreboard: queue empty, want one entry"); end
    else begin
      e = exp_q.pop_front();
      if (held !== e) begin tests_failed++; $display("FAIL t2_scoreboard: got %h want %h", held, e); end
    end
    for (int i = 0; i < 20; i++) begin
      col_busy = {$urandom, $urandom};
      en = 1'($urandom_range(0, 1));
      @(negedge clk);
      tests_run++;
      if (sp_if.spawn_valid !== 1'b1 || {sp_if.spawn_char, sp_if.spawn_col, sp_if.spawn_speed} !== held) begin
        tests_failed++; $display("FAIL t2_hold_stable: cycle %0d got v=%b %h want v=1 %h", i, sp_if.spawn_valid,
          {sp_if.spawn_char, sp_if.spawn_col, sp_if.spawn_speed}, held);
      end
    end
    col_busy = '0; en = 1'b1; sp_if.spawn_ready = 1'b1;
    @(negedge clk);
    sp_if.spawn_ready = 1'b0;
    tests_run++; if (sp_if.spawn_valid !== 1'b0) begin tests_failed++; $display("FAIL t2_valid_drop: got %b want 0", sp_if.spawn_valid); end
    tests_run++; if (spawn_count !== 16'd1) begin tests_failed++; $display("FAIL t2_count: got %0d want 1", spawn_count); end
  endtask

  task automatic test_drop();
    int saw_valid;
    saw_valid = 0;
    do_reset(1'b1, 1'b1, '1);
    for (int c = 1; c <= 12 * 262; c++) begin
      @(negedge clk);
      if (sp_if.spawn_valid !== 1'b0) saw_valid++;
      if (c == 11 || c == 12 || c == 12 * 255 - 1 || c == 12 * 255 || c == 12 * 262) begin
        automatic int want = (c == 11) ? 0 : (c == 12) ? 1 : (c == 12 * 255 - 1) ? 254 : 255;
        tests_run++;
        if (drop_count !== 8'(want)) begin tests_failed++; $display("FAIL t3_drop_count: cycle %0d got %0d want %0d", c, drop_count, want); end
      end
    end
    tests_run++; if (saw_valid !== 0) begin tests_failed++; $display("FAIL t3_no_valid: got %0d valid cycles want 0", saw_valid); end
    tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL t3_scoreboard: got %0d queued want 0", exp_q.size()); end
  endtask

  task automatic test_level();
    int rise, exp_lvl, want_int;
    payload_t e;
    do_reset(1'b1, 1'b1, '0);
    for (int k = 0; k < 32; k++) begin
      exp_lvl  = ref_level(k);
      want_int = (k == 0) ? BASE + 1 : ref_period(exp_lvl) + 2;
      wait_rise(20, rise);
      tests_run++;
      if (rise !== want_int) begin tests_failed++; $display("FAIL t4_interval: spawn %0d got %0d want %0d", k, rise, want_int); end
      tests_run++;
      if (level !== 4'(exp_lvl)) begin tests_failed++; $display("FAIL t4_level: spawn %0d got %0d want %0d", k, level, exp_lvl); end
      tests_run++;
      if (sp_if.spawn_speed == 3'd0 || int'(sp_if.spawn_speed) > exp_lvl + 1) begin
        tests_failed++; $display("FAIL t4_speed_cap: spawn %0d got %0d want 1..%0d", k, sp_if.spawn_speed, exp_lvl + 1);
      end
      tests_run++;
      if (exp_q.size() == 0) begin tests_failed++; $display("FAIL t4_scoreboard: spawn %0d queue empty", k); end
      else begin
        e = exp_q.pop_front();
        if ({sp_if.spawn_char, sp_if.spawn_col, sp_if.spawn_speed} !== e) begin
          tests_failed++; $display("FAIL t4_scoreboard: spawn %0d got %h want %h", k,
            {sp_if.spawn_char, sp_if.spawn_col, sp_if.spawn_speed}, e);
        end
      end
    end
    @(negedge clk);
    tests_run++; if (level !== 4'd15) begin tests_failed++; $display("FAIL t4_level_sat: got %0d want 15", level); end
    tests_run++; if (spawn_count !== 16'd32) begin tests_failed++; $display("FAIL t4_count: got %0d want 32", spawn_count); end
  endtask

  task automatic test_pause();
    int rise, saw_valid;
    payload_t e;
    saw_valid = 0;
    do_reset(1'b1, 1'b1, '0);
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (sp_if.spawn_valid !== 1'b0) saw_valid++;
    end
    en = 1'b1;
    tests_run++; if (saw_valid !== 0) begin tests_failed++; $display("FAIL t5_paused_valid: got %0d want 0", saw_valid); end
    wait_rise(12, rise);
    tests_run++; if (rise !== 3) begin tests_failed++; $display("FAIL t5_latency: got %0d want 3 after resume", rise); end
    tests_run++;
    if ({sp_if.spawn_char, sp_if.spawn_col, sp_if.spawn_speed} !== {8'h6F, 6'd7, 3'd1}) begin
      tests_failed++; $display("FAIL t5_frozen_lfsr: got %h/%0d/%0d want 6f/7/1", sp_if.spawn_char, sp_if.spawn_col, sp_if.spawn_speed);
    end
    tests_run++;
    if (exp_q.size() == 0) begin tests_failed++; $display("FAIL t5_scoreboard: queue empty"); end
    else begin
      e = exp_q.pop_front();
      if ({sp_if.spawn_char, sp_if.spawn_col, sp_if.spawn_speed} !== e) begin
        tests_failed++; $display("FAIL t5_scoreboard: got %h want %h", {sp_if.spawn_char, sp_if.spawn_col, sp_if.spawn_speed}, e);
      end
    end
  endtask

  task automatic test_reset_in_hold();
    int rise, waited;
    do_reset(1'b1, 1'b1, '0);
    waited = 0;
    while (spawn_count !== 16'd3 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    sp_if.spawn_ready = 1'b0;
    tests_run++; if (spawn_count !== 16'd3) begin tests_failed++; $display("FAIL t6_pre_count: got %0d want 3", spawn_count); end
    wait_rise(20, rise);
    tests_run++; if (rise == 0) begin tests_failed++; $display("FAIL t6_hold_timeout: got no valid want valid"); end
    tests_run++; if (level !== 4'd1) begin tests_failed++; $display("FAIL t6_pre_level: got %0d want 1", level); end
    reset = 1'b1;
    sp_if.spawn_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (sp_if.spawn_valid !== 1'b0) begin tests_failed++; $display("FAIL t6_valid: got %b want 0", sp_if.spawn_valid); end
    tests_run++; if (level !== 4'd0) begin tests_failed++; $display("FAIL t6_level: got %0d want 0", level); end
    tests_run++; if (spawn_count !== 16'd0) begin tests_failed++; $display("FAIL t6_count: got %0d want 0", spawn_count); end
    tests_run++; if (drop_count !== 8'd0) begin tests_failed++; $display("FAIL t6_drops: got %0d want 0", drop_count); end
    exp_q.delete();
    reset = 1'b0;
    wait_rise(12, rise);
    tests_run++; if (rise !== 5) begin tests_failed++; $display("FAIL t6_relaunch: got cycle %0d want 5", rise); end
    tests_run++;
    if ({sp_if.spawn_char, sp_if.spawn_col, sp_if.spawn_speed} !== {8'h6F, 6'd7, 3'd1}) begin
      tests_failed++; $display("FAIL t6_seed_payload: got %h/%0d/%0d want 6f/7/1", sp_if.spawn_char, sp_if.spawn_col, sp_if.spawn_speed);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sp_if.spawn_ready = 1'b0; col_busy = '0;
    test_reset();
    test_first_spawn();
    test_hold();
    test_drop();
    test_level();
    test_pause();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
